// File: rtl/mlp_ctrl_pkg.sv
// Shared types and helpers for the MLP accelerator control path.
package mlp_ctrl_pkg;

  localparam int NumReqDefault  = 4;
  localparam int NumRegsDefault = 8;

  // Widest decode the helper supports; callers truncate to their bank size.
  localparam int OnehotMaxWidth = 256;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Binary index to one-hot; indices beyond the supported width decode to zero.
  function automatic logic [OnehotMaxWidth-1:0] onehot_decode(input int unsigned idx);
    logic [OnehotMaxWidth-1:0] vec;
    vec    = '0;
    vec[0] = 1'b1;
    vec    = vec << idx;
    return vec;
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Rotate-and-find-first picker: first valid requester at or after ptr_i, wrapping.
module rr_priority_select
  import mlp_ctrl_pkg::*;
#(
  parameter int NumReq = NumReqDefault
) (
  input  logic [NumReq-1:0]         valid_i,
  input  logic [$clog2(NumReq)-1:0] ptr_i,
  output logic [NumReq-1:0]         grant_o,
  output logic [$clog2(NumReq)-1:0] idx_o
);

  localparam int IdW = $clog2(NumReq);

  // Scan NumReq candidates starting from the pointer and keep the first hit.
  always_comb begin
    int          cand;
    logic        found;
    logic [NumReq-1:0] shifted;
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = 0;
    shifted = '0;
    for (int i = 0; i < NumReq; i++) begin
      cand = int'(ptr_i) + i;
      if (cand >= NumReq) cand = cand - NumReq;
      shifted = valid_i >> cand;
      if (!found && shifted[0]) begin
        found   = 1'b1;
        grant_o = {{(NumReq-1){1'b0}}, 1'b1} << cand;
        idx_o   = IdW'(cand);
      end
    end
  end

endmodule

// File: rtl/reg_bank_write_arbiter.sv
// Round-robin write arbiter with locked multi-beat ownership in front of a register bank.
module reg_bank_write_arbiter
  import mlp_ctrl_pkg::*;
#(
  parameter int NumReq  = NumReqDefault,
  parameter int NumRegs = NumRegsDefault,
  parameter int DWidth  = 32,
  parameter int AWidth  = $clog2(NumRegs)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NumReq-1:0]          req_valid_i,
  input  logic [NumReq*AWidth-1:0]   req_addr_i,
  input  logic [NumReq*DWidth-1:0]   req_data_i,
  input  logic [NumReq-1:0]          req_lock_i,
  output logic [NumReq-1:0]          req_ready_o,
  output logic [NumRegs-1:0]         reg_write_en_o,
  output logic [DWidth-1:0]          reg_write_data_o,
  output logic [$clog2(NumReq)-1:0]  grant_id_o,
  output logic                       locked_o,
  output logic                       addr_err_o
);

  localparam int IdW = $clog2(NumReq);

  arb_state_e         state_q;
  logic [IdW-1:0]     ptr_q;
  logic [IdW-1:0]     owner_q;
  logic [NumRegs-1:0] wen_q;
  logic               err_q;

  logic [NumReq-1:0]  pick_grant;
  logic [IdW-1:0]     pick_idx;
  logic [NumReq-1:0]  ready;
  logic [IdW-1:0]     gidx;
  logic               xfer;
  logic [AWidth-1:0]  addr_sel;
  logic [DWidth-1:0]  data_sel;
  logic [NumReq-1:0]  lock_shift;
  logic               lock_sel;
  logic               addr_ok;

  rr_priority_select #(
    .NumReq(NumReq)
  ) u_pick (
    .valid_i (req_valid_i),
    .ptr_i   (ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx)
  );

  // Grant selection and mux of the winning requester's address/data/lock.
  always_comb begin
    ready = '0;
    if (!rst_i) begin
      if (state_q == ARB_IDLE) ready = pick_grant;
      else ready = req_valid_i & ({{(NumReq-1){1'b0}}, 1'b1} << owner_q);
    end
    xfer       = |ready;
    gidx       = (state_q == ARB_LOCKED) ? owner_q : pick_idx;
    addr_sel   = AWidth'(req_addr_i >> (32'(gidx) * AWidth));
    data_sel   = DWidth'(req_data_i >> (32'(gidx) * DWidth));
    lock_shift = req_lock_i >> gidx;
    lock_sel   = lock_shift[0];
    addr_ok    = 32'(addr_sel) < NumRegs;
  end

  // Arbitration FSM, pointer/owner tracking and the registered bank-side outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q          <= ARB_IDLE;
      ptr_q            <= '0;
      owner_q          <= '0;
      wen_q            <= '0;
      err_q            <= 1'b0;
      reg_write_data_o <= '0;
      grant_id_o       <= '0;
    end else begin
      wen_q <= '0;
      err_q <= 1'b0;
      if (xfer) begin
        grant_id_o <= gidx;
        if (addr_ok) begin
          wen_q            <= NumRegs'(onehot_decode(32'(addr_sel)));
          reg_write_data_o <= data_sel;
        end else begin
          err_q <= 1'b1;
        end
        case (state_q)
          ARB_IDLE: begin
            if (lock_sel) begin
              state_q <= ARB_LOCKED;
              owner_q <= gidx;
            end else begin
              ptr_q <= (gidx == IdW'(NumReq-1)) ? '0 : gidx + 1'b1;
            end
          end
          ARB_LOCKED: begin
            if (!lock_sel) begin
              state_q <= ARB_IDLE;
              ptr_q   <= (owner_q == IdW'(NumReq-1)) ? '0 : owner_q + 1'b1;
            end
          end
          default: state_q <= ARB_IDLE;
        endcase
      end
    end
  end

  // Reset is synchronous, so a strobe captured just before reset would still be
  // presented during the reset cycle; masking here keeps the bank from being written.
  assign reg_write_en_o = wen_q & {NumRegs{~rst_i}};
  assign addr_err_o     = err_q & ~rst_i;
  assign locked_o       = (state_q == ARB_LOCKED);
  assign req_ready_o    = ready;

endmodule

// File: tb/tb_reg_bank_write_arbiter.sv
// Directed bench for reg_bank_write_arbiter with NumReq=4, NumRegs=6.
module tb_reg_bank_write_arbiter;

  localparam int NR = 4;
  localparam int NG = 6;
  localparam int DW = 32;
  localparam int AW = 3;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [NR-1:0]     req_valid_i;
  logic [NR*AW-1:0]  req_addr_i;
  logic [NR*DW-1:0]  req_data_i;
  logic [NR-1:0]     req_lock_i;
  logic [NR-1:0]     req_ready_o;
  logic [NG-1:0]     reg_write_en_o;
  logic [DW-1:0]     reg_write_data_o;
  logic [1:0]        grant_id_o;
  logic              locked_o;
  logic              addr_err_o;

  logic [NR-1:0] va, la;
  logic [AW-1:0] aa [NR];
  logic [DW-1:0] da [NR];

  int compared   = 0;
  int mismatched = 0;

  always #5 clk_i = ~clk_i;

  always_comb begin
    req_addr_i = '0;
    req_data_i = '0;
    for (int i = 0; i < NR; i++) begin
      req_addr_i[i*AW +: AW] = aa[i];
      req_data_i[i*DW +: DW] = da[i];
    end
    req_valid_i = va;
    req_lock_i  = la;
  end

  reg_bank_write_arbiter #(
    .NumReq (NR),
    .NumRegs(NG),
    .DWidth (DW)
  ) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .req_valid_i      (req_valid_i),
    .req_addr_i       (req_addr_i),
    .req_data_i       (req_data_i),
    .req_lock_i       (req_lock_i),
    .req_ready_o      (req_ready_o),
    .reg_write_en_o   (reg_write_en_o),
    .reg_write_data_o (reg_write_data_o),
    .grant_id_o       (grant_id_o),
    .locked_o         (locked_o),
    .addr_err_o       (addr_err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int i, input logic v, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic l);
    va[i] = v;
    aa[i] = a;
    da[i] = d;
    la[i] = l;
  endtask

  task automatic all_default();
    for (int i = 0; i < NR; i++) drive(i, 1'b1, AW'(i), DW'(32'h10 + i), 1'b0);
  endtask

  // Check the combinational grant mid-cycle, then advance to just after the next edge.
  task automatic step(input string tag, input logic [NR-1:0] exp_ready);
    @(negedge clk_i);
    chk(tag, 32'(req_ready_o), 32'(exp_ready));
    @(posedge clk_i);
    #1;
  endtask

  task automatic post(input string tag, input logic [NG-1:0] wen, input logic [DW-1:0] data,
                      input logic [1:0] id, input logic lk, input logic err);
    chk({tag, "_wen"},  32'(reg_write_en_o), 32'(wen));
    chk({tag, "_data"}, reg_write_data_o, data);
    chk({tag, "_id"},   32'(grant_id_o), 32'(id));
    chk({tag, "_lock"}, 32'(locked_o), 32'(lk));
    chk({tag, "_err"},  32'(addr_err_o), 32'(err));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_g [6];
    exp_g = '{0, 1, 2, 3, 0, 1};

    // Reset with every requester valid: nothing may be granted.
    rst_i = 1'b1;
    all_default();
    step("rst_ready", 4'b0000);
    step("rst_ready2", 4'b0000);
    rst_i = 1'b0;
    post("rst", 6'h00, 32'h0, 2'd0, 1'b0, 1'b0);

    // All requesters valid: round-robin 0,1,2,3,0,1 with strobes one cycle later.
    for (int k = 0; k < 6; k++) begin
      step($sformatf("rr%0d_ready", k), 4'(1 << exp_g[k]));
      post($sformatf("rr%0d", k), 6'(1 << exp_g[k]), DW'(32'h10 + exp_g[k]),
           2'(exp_g[k]), 1'b0, 1'b0);
    end

    // Locked burst by requester 2 (ptr=2) while 0 and 1 wait; 3 idle.
    drive(3, 1'b0, 3'd0, 32'h0, 1'b0);
    drive(2, 1'b1, 3'd2, 32'hA0, 1'b1);
    step("lk1_ready", 4'b0100);
    post("lk1", 6'h04, 32'hA0, 2'd2, 1'b1, 1'b0);
    drive(2, 1'b1, 3'd3, 32'hA1, 1'b1);
    step("lk2_ready", 4'b0100);
    post("lk2", 6'h08, 32'hA1, 2'd2, 1'b1, 1'b0);
    drive(2, 1'b1, 3'd4, 32'hA2, 1'b0);
    step("lk3_ready", 4'b0100);
    post("lk3", 6'h10, 32'hA2, 2'd2, 1'b0, 1'b0);
    // ptr=3 with requester 3 idle: wraps to 0.
    drive(2, 1'b0, 3'd2, 32'h12, 1'b0);
    step("wrap_ready", 4'b0001);
    post("wrap", 6'h01, 32'h10, 2'd0, 1'b0, 1'b0);

    // Owner 1 locks, then drops valid for two cycles: bubbles, no strobes.
    all_default();
    drive(1, 1'b1, 3'd1, 32'hB1, 1'b1);
    step("own_ready", 4'b0010);
    post("own", 6'h02, 32'hB1, 2'd1, 1'b1, 1'b0);
    drive(1, 1'b0, 3'd1, 32'hB1, 1'b1);
    step("bub1_ready", 4'b0000);
    post("bub1", 6'h00, 32'hB1, 2'd1, 1'b1, 1'b0);
    step("bub2_ready", 4'b0000);
    post("bub2", 6'h00, 32'hB1, 2'd1, 1'b1, 1'b0);
    drive(1, 1'b1, 3'd5, 32'hB2, 1'b0);
    step("res_ready", 4'b0010);
    post("res", 6'h20, 32'hB2, 2'd1, 1'b0, 1'b0);

    // Out-of-range addresses 7 and 6 (NumRegs=6): accepted, dropped, error pulse.
    va = '0;
    drive(2, 1'b1, 3'd7, 32'hDEAD, 1'b0);
    step("err7_ready", 4'b0100);
    post("err7", 6'h00, 32'hB2, 2'd2, 1'b0, 1'b1);
    drive(2, 1'b0, 3'd7, 32'hDEAD, 1'b0);
    drive(3, 1'b1, 3'd6, 32'hBEEF, 1'b0);
    step("err6_ready", 4'b1000);
    post("err6", 6'h00, 32'hB2, 2'd3, 1'b0, 1'b1);
    va = '0;
    step("none_ready", 4'b0000);
    post("none", 6'h00, 32'hB2, 2'd3, 1'b0, 1'b0);

    // Move ptr to 1, lock on requester 2, then reset right after an in-lock transfer.
    drive(0, 1'b1, 3'd0, 32'hC0, 1'b0);
    step("pre_ready", 4'b0001);
    post("pre", 6'h01, 32'hC0, 2'd0, 1'b0, 1'b0);
    drive(0, 1'b0, 3'd0, 32'hC0, 1'b0);
    drive(2, 1'b1, 3'd1, 32'hC1, 1'b1);
    step("rl1_ready", 4'b0100);
    post("rl1", 6'h02, 32'hC1, 2'd2, 1'b1, 1'b0);
    drive(2, 1'b1, 3'd2, 32'hC2, 1'b1);
    step("rl2_ready", 4'b0100);
    rst_i = 1'b1;
    all_default();
    #1;
    chk("rst_mask_wen", 32'(reg_write_en_o), 32'h0);
    chk("rst_mask_ready", 32'(req_ready_o), 32'h0);
    @(posedge clk_i);
    #1;
    chk("rst_lock", 32'(locked_o), 32'h0);
    chk("rst_wen", 32'(reg_write_en_o), 32'h0);
    chk("rst_id", 32'(grant_id_o), 32'h0);
    rst_i = 1'b0;
    step("after_rst_ready", 4'b0001);
    post("after_rst", 6'h01, 32'h10, 2'd0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/reg_bank_write_arbiter.md
# reg_bank_write_arbiter

Round-robin write arbiter that shares one bank of NumRegs configuration/weight registers among NumReq independent requesters (layer controller, host loader, debug port, ...). It accepts at most one write per cycle via a valid/ready handshake, supports locked multi-beat ownership, and drives a registered one-hot write-enable vector plus a shared data bus into the register bank. It sits between the MLP accelerator's control sources and its register storage.

## Interface
- NumReq, 4: number of requesters, ≥2.
- NumRegs, 8: number of registers in the bank, ≥2, need not be a power of two.
- DWidth, 32: register data width.
- AWidth, $clog2(NumRegs): address width (derived; do not override).
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- req_valid_i  in  NumReq  per-requester write request.
- req_addr_i  in  NumReq×AWidth  per-requester target register index.
- req_data_i  in  NumReq×DWidth  per-requester write data.
- req_lock_i  in  NumReq  hold ownership after this beat.
- req_ready_o  out  NumReq  one-hot grant; a transfer occurs on valid & ready.
- reg_write_en_o  out  NumRegs  registered one-hot bank write enable.
- reg_write_data_o  out  DWidth  registered write data.
- grant_id_o  out  $clog2(NumReq)  requester index of the last accepted transfer.
- locked_o  out  1  high while the FSM is in LOCKED.
- addr_err_o  out  1  one-cycle pulse: accepted write had address ≥ NumRegs.

## Operation
- FSM states: IDLE (free arbitration) and LOCKED (owner held in owner_q).
- IDLE: grant goes to the first valid requester scanning from ptr_q upward, wrapping modulo NumReq. req_ready_o is combinational, at most one bit set, and low for all requesters when none is valid.
- On a transfer from requester g in IDLE: if req_lock_i[g]=1, go to LOCKED with owner_q=g and leave ptr_q unchanged. Otherwise ptr_q ← (g+1) mod NumReq.
- LOCKED: only owner_q can be granted. If the owner is not valid, no grant is issued that cycle (bubble) and others keep waiting.
- A LOCKED transfer with req_lock_i[owner]=0 returns the FSM to IDLE and sets ptr_q ← (owner_q+1) mod NumReq.
- Accepted write with addr < NumRegs: next cycle reg_write_en_o[addr]=1 for exactly one cycle, and reg_write_data_o carries the data.
- Accepted write with addr ≥ NumRegs: the write is accepted and dropped. reg_write_en_o stays all-zero, and addr_err_o pulses in the same cycle the write would have appeared.
- reg_write_data_o holds its last value when no write occurs.
- grant_id_o updates on every transfer and holds otherwise.
- The bank never back-pressures, so throughput is one write per cycle.

## Timing
- Reset values: state IDLE, ptr_q=0, owner_q=0, reg_write_en_o=0, reg_write_data_o=0, grant_id_o=0, locked_o=0, addr_err_o=0.
- req_ready_o is 0 during reset.
- Latency: transfer in cycle N gives the bank write strobe in cycle N+1; register contents are visible in N+2.
- Back-to-back transfers produce back-to-back strobes with no bubble.
- locked_o rises in the cycle after the locking transfer. It falls in the cycle after the unlocking transfer.
- Reset asserted mid-lock or with a write pending: FSM goes to IDLE, and the pending strobe is suppressed (the register is not written).
- Requester deasserting valid without a transfer is legal. Data and address must be stable only in the transfer cycle.

## Structure
- Package mlp_ctrl_pkg holds:
  - the arb_state_e enum {ARB_IDLE, ARB_LOCKED};
  - helper function onehot_decode;
  - NumReq/NumRegs defaults as localparams.
- One sub-module: rr_priority_select, a combinational rotate-and-find-first picker. Inputs are the valid vector and ptr; outputs are a one-hot grant and a binary index.
- The top level contains the FSM, the pointer/owner registers and the output register stage.

## Test plan
- Reset, then all four requesters valid continuously with addr=i and data=0x10+i:
  - grants cycle 0,1,2,3,0 (one per cycle);
  - reg_write_en_o = 0x01,0x02,0x04,0x08 one cycle after each grant.
- Requester 2 sends 3 beats with lock=1,1,0 while requesters 0 and 1 are valid:
  - requester 2 gets all three consecutive grants and locked_o is high over the burst;
  - the next grant goes to requester 3 if valid, else wraps to 0.
- Locked owner deasserts valid for 2 cycles while others are valid:
  - no req_ready_o bits are set and no strobes are issued;
  - ownership resumes when the owner is valid again.
- NumRegs=6, addr=7, data=0xDEAD:
  - req_ready_o asserts;
  - the next cycle shows addr_err_o=1 and reg_write_en_o=0;
  - no register changes.
- rst_i asserted in the cycle right after a transfer inside a lock:
  - no write strobe, locked_o=0, ptr_q=0;
  - the next arbitration starts at requester 0.
